// File: rtl/perceptron_train_sequencer.sv
// Training-set store and epoch sequencer that feeds a standalone perceptron stage.
// Define PERCEPTRON_SEQ_EARLY_STOP_EN to end training on the first zero-error epoch.
module perceptron_train_sequencer #(
  parameter int INPUT_UNITS = 2,
  parameter int DEPTH       = 4,
  parameter int MAX_EPOCHS  = 64,
  parameter int SFP_W       = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  load_valid_i,
  output logic                                  load_ready_o,
  input  logic [INPUT_UNITS-1:0][SFP_W-1:0]     load_values_i,
  input  logic [SFP_W-1:0]                      load_expected_i,
  input  logic                                  clear_i,
  input  logic                                  start_i,
  input  logic [SFP_W-1:0]                      lr_in_i,
  output logic [INPUT_UNITS-1:0][SFP_W-1:0]     values_o,
  output logic [SFP_W-1:0]                      expected_o,
  output logic [SFP_W-1:0]                      learning_rate_o,
  output logic                                  training_o,
  input  logic [SFP_W-1:0]                      prediction_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  converged_o,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]       epoch_count_o,
  output logic [$clog2(DEPTH+1)-1:0]            error_count_o
);

  localparam int EW = $clog2(MAX_EPOCHS + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRAIN = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [EW-1:0] EP_MAX  = EW'(MAX_EPOCHS);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    errs_q, errs_d;
  logic [EW-1:0]    epoch_q, epoch_d;
  logic [CW-1:0]    errcnt_q, errcnt_d;
  logic             conv_q, conv_d;
  logic [SFP_W-1:0] lr_q, lr_d;

  logic [INPUT_UNITS-1:0][SFP_W-1:0] store_vals_q [DEPTH];
  logic [SFP_W-1:0]                  store_exp_q  [DEPTH];

  logic          idle_like;
  logic          clear_ok;
  logic          load_fire;
  logic          start_ok;
  logic          last_idx;
  logic          miss;
  logic          early_exit;
  logic [CW-1:0] errs_inc;
  logic [EW-1:0] epoch_next;

  assign idle_like    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign load_ready_o = idle_like && (count_q < DEPTH_C);
  assign load_fire    = load_valid_i && load_ready_o;
  // Clearing mid-epoch would pull the sample count out from under idx, so it waits for IDLE/DONE.
  assign clear_ok     = clear_i && idle_like;
  assign start_ok     = idle_like && start_i && (count_q != '0) && !load_fire && !clear_ok;

  assign values_o        = store_vals_q[idx_q];
  assign expected_o      = store_exp_q[idx_q];
  assign learning_rate_o = lr_q;
  assign training_o      = (state_q == S_TRAIN);
  assign busy_o          = (state_q == S_TRAIN) || (state_q == S_CHECK);
  assign done_o          = (state_q == S_DONE);
  assign converged_o     = conv_q;
  assign epoch_count_o   = epoch_q;
  assign error_count_o   = errcnt_q;

  assign last_idx   = (CW'(idx_q) == (count_q - CW'(1)));
  assign miss       = (prediction_i != store_exp_q[idx_q]);
  assign errs_inc   = (miss && (errs_q != DEPTH_C)) ? (errs_q + CW'(1)) : errs_q;
  assign epoch_next = epoch_q + EW'(1);

`ifdef PERCEPTRON_SEQ_EARLY_STOP_EN
  assign early_exit = (errs_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    errs_d   = errs_q;
    epoch_d  = epoch_q;
    errcnt_d = errcnt_q;
    conv_d   = conv_q;
    lr_d     = lr_q;

    if (clear_ok) begin
      count_d = '0;
    end else if (load_fire) begin
      count_d = count_q + CW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          lr_d    = lr_in_i;
          idx_d   = '0;
          errs_d  = '0;
          epoch_d = '0;
          conv_d  = 1'b0;
          state_d = S_TRAIN;
        end
      end
      S_TRAIN: begin
        errs_d = errs_inc;
        if (last_idx) begin
          state_d = S_CHECK;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_CHECK: begin
        errcnt_d = errs_q;
        epoch_d  = epoch_next;
        conv_d   = (errs_q == '0);
        if ((epoch_next == EP_MAX) || early_exit) begin
          state_d = S_DONE;
        end else begin
          idx_d   = '0;
          errs_d  = '0;
          state_d = S_TRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      errs_q   <= '0;
      epoch_q  <= '0;
      errcnt_q <= '0;
      conv_q   <= 1'b0;
      lr_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      errs_q   <= errs_d;
      epoch_q  <= epoch_d;
      errcnt_q <= errcnt_d;
      conv_q   <= conv_d;
      lr_q     <= lr_d;
    end
  end

  // Sample store; a simultaneous clear discards the incoming sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_vals_q[i] <= '0;
        store_exp_q[i]  <= '0;
      end
    end else if (load_fire && !clear_ok) begin
      store_vals_q[IW'(count_q)] <= load_values_i;
      store_exp_q[IW'(count_q)]  <= load_expected_i;
    end
  end

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Scoreboard bench for perceptron_train_sequencer with a fixed-function perceptron stand-in.
// Expected run results are pushed at start; a monitor pops and compares them when done rises.
module tb_perceptron_train_sequencer;

  localparam int SFP_W = 16;
  localparam int MAXE  = 8;
  localparam logic [SFP_W-1:0] ONE = 16'h0100;
`ifdef PERCEPTRON_SEQ_EARLY_STOP_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic clk;
  logic rstN;
  logic loadValid;
  logic loadReady;
  logic [1:0][SFP_W-1:0] loadValues;
  logic [SFP_W-1:0] loadExpected;
  logic clear;
  logic start;
  logic [SFP_W-1:0] lrIn;
  logic [1:0][SFP_W-1:0] values;
  logic [SFP_W-1:0] expectedOut;
  logic [SFP_W-1:0] learningRate;
  logic training;
  logic [SFP_W-1:0] prediction;
  logic busy;
  logic done;
  logic converged;
  logic [3:0] epochCount;
  logic [2:0] errorCount;

  int checks = 0;
  int errors = 0;
  int predMode = 0;

  typedef struct {
    int epochs;
    int errs;
    int conv;
    int busyCycles;
    int trainCycles;
  } expT;
  expT sb[$];

  perceptron_train_sequencer #(
    .INPUT_UNITS(2), .DEPTH(4), .MAX_EPOCHS(MAXE), .SFP_W(SFP_W)
  ) dut (
    .clk_i(clk), .rst_ni(rstN),
    .load_valid_i(loadValid), .load_ready_o(loadReady),
    .load_values_i(loadValues), .load_expected_i(loadExpected),
    .clear_i(clear), .start_i(start), .lr_in_i(lrIn),
    .values_o(values), .expected_o(expectedOut), .learning_rate_o(learningRate),
    .training_o(training), .prediction_i(prediction),
    .busy_o(busy), .done_o(done), .converged_o(converged),
    .epoch_count_o(epochCount), .error_count_o(errorCount)
  );

  // Stand-in perceptron: mode 0 always predicts 0, mode 1 predicts the AND of the inputs.
  always_comb begin
    prediction = '0;
    if (predMode == 1 && values[0] != '0 && values[1] != '0) prediction = ONE;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
    end
  endtask

  task automatic applyStimulus(input logic [SFP_W-1:0] v0, input logic [SFP_W-1:0] v1,
                               input logic [SFP_W-1:0] ex);
    @(negedge clk);
    loadValues[0] = v0;
    loadValues[1] = v1;
    loadExpected = ex;
    loadValid = 1'b1;
    @(negedge clk);
    loadValid = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulseStart(input logic [SFP_W-1:0] lr);
    @(negedge clk);
    start = 1'b1;
    lrIn = lr;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pushExp(input int ep, input int er, input int cv, input int bc, input int tc);
    expT e;
    e.epochs = ep; e.errs = er; e.conv = cv; e.busyCycles = bc; e.trainCycles = tc;
    sb.push_back(e);
  endtask

  task automatic waitDone(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitDone: done still %0b after %0d cycles, expected 1", done, n);
    end
  endtask

  // Monitor: tallies busy/training cycles per run and checks status when done rises.
  initial begin
    int busyCnt;
    int trainCnt;
    logic prevDone;
    expT e;
    busyCnt = 0; trainCnt = 0; prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        busyCnt = 0; trainCnt = 0; prevDone = 1'b0;
      end else begin
        if (busy) busyCnt++;
        if (training) trainCnt++;
        if (done && !prevDone) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDone: got done=1, expected no pending run");
          end else begin
            e = sb.pop_front();
            checkOutput("epochCount", 32'(epochCount), 32'(e.epochs));
            checkOutput("errorCount", 32'(errorCount), 32'(e.errs));
            checkOutput("converged", 32'(converged), 32'(e.conv));
            checkOutput("busyCycles", 32'(busyCnt), 32'(e.busyCycles));
            checkOutput("trainCycles", 32'(trainCnt), 32'(e.trainCycles));
          end
          busyCnt = 0;
          trainCnt = 0;
        end
        prevDone = done;
      end
    end
  end

  initial begin
    int n;
    int e1;
    rstN = 1'b0; loadValid = 1'b0; loadValues = '0; loadExpected = '0;
    clear = 1'b0; start = 1'b0; lrIn = '0;
    e1 = (EARLY != 0) ? 1 : MAXE;

    #12;
    checkOutput("rst loadReady", 32'(loadReady), 32'd1);
    checkOutput("rst training", 32'(training), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst epochCount", 32'(epochCount), 32'd0);
    checkOutput("rst learningRate", 32'(learningRate), 32'd0);
    #11 rstN = 1'b1;

    // Single zero sample, never mispredicted.
    predMode = 0;
    applyStimulus(16'h0, 16'h0, 16'h0);
    pushExp(e1, 0, 1, 2 * e1, e1);
    pulseStart(ONE);
    checkOutput("single busyRise", 32'(busy), 32'd1);
    checkOutput("single learningRate", 32'(learningRate), 32'(ONE));
    waitDone(200, n);
    checkOutput("single doneLatency", 32'(n), 32'(2 * e1));

    // Capacity and clear, leaving an XOR set loaded.
    pulseClear();
    checkOutput("clear loadReady", 32'(loadReady), 32'd1);
    pulseStart(ONE);
    checkOutput("emptyStart busy", 32'(busy), 32'd0);
    applyStimulus(16'h0, 16'h0, 16'h0);
    applyStimulus(16'h0, ONE, ONE);
    applyStimulus(ONE, 16'h0, ONE);
    applyStimulus(ONE, ONE, 16'h0);
    checkOutput("full loadReady", 32'(loadReady), 32'd0);
    applyStimulus(ONE, ONE, ONE);
    checkOutput("fifthLoad loadReady", 32'(loadReady), 32'd0);

    // XOR against AND predictor: samples 1, 2, 3 miss every epoch.
    predMode = 1;
    pushExp(MAXE, 3, 0, 5 * MAXE, 4 * MAXE);
    pulseStart(ONE);
    repeat (3) @(negedge clk);
    pulseStart(16'h0080);
    checkOutput("midStart learningRate", 32'(learningRate), 32'(ONE));
    checkOutput("midStart busy", 32'(busy), 32'd1);
    waitDone(300, n);

    // XOR against constant-zero predictor: samples 1, 2 miss every epoch.
    predMode = 0;
    pushExp(MAXE, 2, 0, 5 * MAXE, 4 * MAXE);
    pulseStart(ONE);
    checkOutput("restart epochCount", 32'(epochCount), 32'd0);
    checkOutput("restart errorCountHeld", 32'(errorCount), 32'd3);
    waitDone(300, n);

    // AND dataset against AND predictor: zero errors.
    pulseClear();
    applyStimulus(16'h0, 16'h0, 16'h0);
    applyStimulus(16'h0, ONE, 16'h0);
    applyStimulus(ONE, 16'h0, 16'h0);
    applyStimulus(ONE, ONE, ONE);
    predMode = 1;
    pushExp(e1, 0, 1, 5 * e1, 4 * e1);
    pulseStart(ONE);
    waitDone(300, n);

    // Start in the same cycle as a load handshake is ignored.
    pulseClear();
    @(negedge clk);
    loadValues[0] = 16'h0; loadValues[1] = ONE; loadExpected = 16'h0;
    loadValid = 1'b1; start = 1'b1; lrIn = ONE;
    @(negedge clk);
    loadValid = 1'b0; start = 1'b0;
    checkOutput("loadStart busy", 32'(busy), 32'd0);
    applyStimulus(ONE, ONE, ONE);

    // Asynchronous reset in the second TRAIN cycle.
    pulseStart(ONE);
    @(negedge clk);
    checkOutput("preReset training", 32'(training), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncRst training", 32'(training), 32'd0);
    checkOutput("asyncRst busy", 32'(busy), 32'd0);
    checkOutput("asyncRst loadReady", 32'(loadReady), 32'd1);
    checkOutput("asyncRst epochCount", 32'(epochCount), 32'd0);
    checkOutput("asyncRst values", 32'(values), 32'd0);
    checkOutput("asyncRst learningRate", 32'(learningRate), 32'd0);
    @(negedge clk);
    #2 rstN = 1'b1;

    // Normal run after reset.
    applyStimulus(ONE, ONE, ONE);
    pushExp(e1, 0, 1, 2 * e1, e1);
    pulseStart(ONE);
    checkOutput("postRst busy", 32'(busy), 32'd1);
    waitDone(200, n);
    checkOutput("postRst doneLatency", 32'(n), 32'(2 * e1));
    checkOutput("postRst loadReady", 32'(loadReady), 32'd1);

    repeat (2) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_train_sequencer.md
# perceptron_train_sequencer

Upstream feeder for the standalone perceptron stage. Holds a small training set loaded through a valid/ready port, replays it sample by sample with `training` asserted, and compares the perceptron's `prediction` against `expected` to count misclassifications per epoch. Epochs repeat until an epoch has zero errors or `MAX_EPOCHS` is reached, then it reports done/converged status to the controlling logic.

## Interface
- `INPUT_UNITS`, 2, sample width in `sfp` elements; must match the perceptron's `input_units`.
- `DEPTH`, 4, maximum number of stored samples (≥1).
- `MAX_EPOCHS`, 64, epoch limit (≥1).
- `clk`  in  1  clock.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-low.
- `load_valid`  in  1  sample write request.
- `load_ready`  out  1  sample write accepted when high with `load_valid`.
- `load_values`  in  `sfp[INPUT_UNITS]`  sample inputs.
- `load_expected`  in  `sfp`  sample label (0 or `ONE`).
- `clear`  in  1  empties the sample store (count to 0).
- `start`  in  1  one-cycle pulse; begins training.
- `lr_in`  in  `sfp`  learning rate, captured at `start`.
- `values`  out  `sfp[INPUT_UNITS]`  to perceptron `values`.
- `expected`  out  `sfp`  to perceptron `expected`.
- `learning_rate`  out  `sfp`  to perceptron `learning_rate`.
- `training`  out  1  to perceptron `training`.
- `prediction`  in  `sfp`  from perceptron.
- `busy`  out  1  high in TRAIN/CHECK.
- `done`  out  1  high in DONE.
- `converged`  out  1  last completed epoch had zero errors.
- `epoch_count`  out  `$clog2(MAX_EPOCHS+1)`  completed epochs.
- `error_count`  out  `$clog2(DEPTH+1)`  errors in last completed epoch.

## Operation
- Reset values: state IDLE, sample count 0, store cleared to 0, `load_ready`=1, `training`=0, `busy`=0, `done`=0, `converged`=0, `epoch_count`=0, `error_count`=0, `learning_rate`=0, index 0.
- Store: `load_ready` = (state is IDLE or DONE) and count < `DEPTH`. On `load_valid && load_ready`, the sample is written at slot `count` and count increments. `clear` sets count to 0; `clear` beats a load in the same cycle.
- `values`/`expected` are always driven combinationally from slot `idx`.
- States:
  - IDLE: `start` with count ≥ 1 and no load handshake or `clear` in that cycle → capture `lr_in`, `idx`=0, epoch errors=0, `epoch_count`=0, `converged`=0 → TRAIN. `start` with count 0, or `start` in a cycle with a load handshake or `clear`, is ignored.
  - TRAIN: `training`=1. Each cycle, a miss is counted when `prediction != expected`. The perceptron's weights update at the same edge, so the comparison uses the pre-update prediction. `idx` increments; at `idx == count-1` → CHECK.
  - CHECK: `training`=0. `error_count` ← epoch errors, `epoch_count`+1, `converged` ← (errors==0). Exit to DONE if converged, or if `epoch_count+1 == MAX_EPOCHS`. Otherwise `idx`=0, errors=0 → TRAIN.
  - DONE: status held. `start` behaves as in IDLE. Loads and `clear` are allowed.
- `start` during TRAIN/CHECK is ignored. Error counter saturates at `DEPTH`.

## Timing
- Epoch = count TRAIN cycles + 1 CHECK cycle.
- `busy` rises the cycle after `start`. `done` rises the cycle after the final CHECK.
- Status outputs update at the CHECK edge and stay stable until the next CHECK or `start`.
- Asserting `rst` mid-epoch immediately and asynchronously returns everything to reset values, including the store. The perceptron's own reset is independent.

## Configuration
- `PERCEPTRON_SEQ_EARLY_STOP_EN` defined: CHECK exits to DONE on a zero-error epoch, as described above.
- Not defined: CHECK never exits early. Training always runs exactly `MAX_EPOCHS` epochs. `converged` still reflects the last epoch.

## Test plan
- Load 1 sample {0,0}, exp 0, `start` with `lr_in`=`ONE` → `training` high 1 cycle. `done` 3 cycles after `start`, `epoch_count`=1, `error_count`=0, `converged`=1.
- Load 4 samples at `DEPTH`=4 → `load_ready`=0 after the 4th. A 5th `load_valid` is not accepted. `clear` → `load_ready`=1, count 0.
- AND dataset (inputs 0/`ONE`), `lr_in`=`ONE`, early stop on → `converged`=1, `epoch_count` < 64, last `error_count`=0. `training` is high exactly 4 of every 5 busy cycles.
- XOR dataset, `MAX_EPOCHS`=8 → `done` after 40 busy cycles, `epoch_count`=8, `converged`=0, `error_count` ≥ 1.
- `start` with count 0, and `start` during TRAIN → no state change, no restart.
- `rst` low during the 2nd TRAIN cycle → `training`=0, `busy`=0, `load_ready`=1, `epoch_count`=0 with no clock edge. A new load plus `start` then runs normally.
